bcd_digit_sequencer: RTL and testbench

- Controller that performs multi-digit packed-BCD addition by time-sharing one external single-digit BCD adder.
- The adder is the combinational digit-add stage: 4-bit a, 4-bit b and carry-in in; corrected 4-bit BCD sum and carry-out back.
- Accepts operand pairs over a valid/ready handshake, checks operand digits, steps the adder LSD to MSD, and presents a packed-BCD result for the HEX display path.

---
 rtl/bcd_digit_sequencer.sv | 175 +++++++++++++++++
 tb/tb_bcd_digit_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_sequencer.sv
// bcd_digit_sequencer
// Multi-digit packed-BCD adder controller. A single external combinational
// BCD digit adder is time-shared, one digit per clock, from the least
// significant digit to the most significant. Operands arrive over a
// valid/ready handshake, and the packed result is held until it is consumed.
module bcd_digit_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   op_a,
    input  logic [4*DIGITS-1:0]   op_b,
    input  logic                  cin,
    output logic [3:0]            dig_a,
    output logic [3:0]            dig_b,
    output logic                  dig_cin,
    input  logic [3:0]            dig_sum,
    input  logic                  dig_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err,
    output logic                  busy
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_ADD   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    logic [1:0]    state_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  result_r;
    logic          cin_r;
    logic          carry_r;
    logic          cout_r;
    logic          err_r;
    logic [IW-1:0] idx_r;

    logic [3:0]    dig_a_s;
    logic [3:0]    dig_b_s;
    logic          dig_cin_s;

    // True when any nibble of the packed value is not a decimal digit.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Select nibble idx of a packed value; out-of-range indices yield zero.
    function automatic logic [3:0] digit_at(input logic [W-1:0] v,
                                            input logic [IW-1:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                d = v[4*i +: 4];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // Drive the shared adder only while adding; elsewhere it sees zeros.
    always_comb begin
        dig_a_s   = 4'd0;
        dig_b_s   = 4'd0;
        dig_cin_s = 1'b0;
        if (state_r == ST_ADD) begin
            dig_a_s   = digit_at(a_r, idx_r);
            dig_b_s   = digit_at(b_r, idx_r);
            dig_cin_s = carry_r;
        end else begin
            dig_a_s   = 4'd0;
            dig_b_s   = 4'd0;
            dig_cin_s = 1'b0;
        end
    end

    // Control state machine: accept, validate, ripple digits, hand off result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            cin_r    <= 1'b0;
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
            err_r    <= 1'b0;
            idx_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r      <= op_a;
                        b_r      <= op_b;
                        cin_r    <= cin;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                        err_r    <= 1'b0;
                        idx_r    <= '0;
                        state_r  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (has_bad_digit(a_r) || has_bad_digit(b_r)) begin
                        err_r    <= 1'b1;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end else begin
                        carry_r  <= cin_r;
                        state_r  <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_r == IW'(i)) begin
                            result_r[4*i +: 4] <= dig_sum;
                        end
                    end
                    carry_r <= dig_cout;
                    idx_r   <= idx_r + 1'b1;
                    // A non-decimal digit from the adder poisons the result
                    // but the ripple still runs to completion.
                    if (dig_sum > 4'd9) begin
                        err_r <= 1'b1;
                    end
                    if (idx_r == LAST_IDX) begin
                        cout_r  <= dig_cout;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign result    = result_r;
    assign cout      = cout_r;
    assign err       = err_r;
    assign dig_a     = dig_a_s;
    assign dig_b     = dig_b_s;
    assign dig_cin   = dig_cin_s;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed bench for bcd_digit_sequencer with DIGITS=4 and a behavioural
// single-digit BCD adder closing the loop.
module tb_bcd_digit_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic [3:0]  dig_a;
    logic [3:0]  dig_b;
    logic        dig_cin;
    logic [3:0]  dig_sum;
    logic        dig_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        err;
    logic        busy;

    int checks;
    int errors;

    logic [3:0] tr_a [0:19];
    logic [3:0] tr_b [0:19];
    logic       tr_c [0:19];
    int         lat;

    bcd_digit_sequencer #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .dig_a(dig_a), .dig_b(dig_b), .dig_cin(dig_cin),
        .dig_sum(dig_sum), .dig_cout(dig_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural decimal digit adder.
    logic [4:0] raw_s;
    logic [4:0] adj_s;
    always_comb begin
        raw_s = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, dig_cin};
        adj_s = raw_s - 5'd10;
        if (raw_s > 5'd9) begin
            dig_sum  = adj_s[3:0];
            dig_cout = 1'b1;
        end else begin
            dig_sum  = raw_s[3:0];
            dig_cout = 1'b0;
        end
    end

    // Accept one operation, trace the adder bus, wait for the result, then
    // check it and release it.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] exp_res, input logic exp_cout,
                          input logic exp_err, input int exp_lat, input string name);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        op_a = a; op_b = b; cin = c; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = ~c;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tr_a[k] = dig_a; tr_b[k] = dig_b; tr_c[k] = dig_cin;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (result !== exp_res || cout !== exp_cout || err !== exp_err) begin
            errors++;
            $display("FAIL %s result: got %h/%b/%b want %h/%b/%b", name,
                     result, cout, err, exp_res, exp_cout, exp_err);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s done flags: in_ready %b busy %b want 0 1", name, in_ready, busy);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: out_valid %b in_ready %b busy %b want 0 1 0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = 16'h0; op_b = 16'h0; cin = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 16'h0 ||
            cout !== 1'b0 || err !== 1'b0 || dig_a !== 4'd0 || dig_b !== 4'd0 || dig_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov %b ir %b busy %b res %h cout %b err %b dig %h %h %b",
                     out_valid, in_ready, busy, result, cout, err, dig_a, dig_b, dig_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] ea [1:4];
        logic [3:0] eb [1:4];
        logic       ec [1:4];
        ea[1] = 4'd4; eb[1] = 4'd8; ec[1] = 1'b0;
        ea[2] = 4'd3; eb[2] = 4'd7; ec[2] = 1'b1;
        ea[3] = 4'd2; eb[3] = 4'd6; ec[3] = 1'b1;
        ea[4] = 4'd1; eb[4] = 4'd5; ec[4] = 1'b0;
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5, "basic");
        checks++;
        if (tr_a[0] !== 4'd0 || tr_b[0] !== 4'd0 || tr_c[0] !== 1'b0) begin
            errors++; $display("FAIL basic check_cycle_bus: got %h %h %b want 0 0 0", tr_a[0], tr_b[0], tr_c[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (tr_a[k] !== ea[k] || tr_b[k] !== eb[k] || tr_c[k] !== ec[k]) begin
                errors++;
                $display("FAIL basic pair%0d: got %h %h %b want %h %h %b", k,
                         tr_a[k], tr_b[k], tr_c[k], ea[k], eb[k], ec[k]);
            end
        end
    endtask

    task automatic test_boundary();
        run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 5, "sum10");
    endtask

    task automatic test_ripple();
        run_op(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 5, "ripple");
    endtask

    task automatic test_bad_digit();
        run_op(16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1, "bad_digit");
        checks++;
        if (tr_a[0] !== 4'd0 || tr_b[0] !== 4'd0 || tr_c[0] !== 1'b0 ||
            tr_a[1] !== 4'd0 || tr_b[1] !== 4'd0 || tr_c[1] !== 1'b0) begin
            errors++;
            $display("FAIL bad_digit bus_idle: got %h %h %b / %h %h %b want zeros",
                     tr_a[0], tr_b[0], tr_c[0], tr_a[1], tr_b[1], tr_c[1]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        @(negedge clk);
        op_a = 16'h0011; op_b = 16'h0022; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        op_a = 16'h1111; op_b = 16'h2222;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL backpressure timeout: out_valid %b want 1", out_valid);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0033 || cout !== 1'b0) begin
                errors++;
                $display("FAIL backpressure hold%0d: ov %b ir %b res %h cout %b want 1 0 0033 0",
                         k, out_valid, in_ready, result, cout);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure release: ov %b ir %b want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h3333 || err !== 1'b0) begin
            errors++; $display("FAIL backpressure next_op: ov %b res %h err %b want 1 3333 0", out_valid, result, err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dig_a !== 4'd3 || dig_b !== 4'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset second_add: dig %h %h busy %b want 3 1 1", dig_a, dig_b, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 16'h0 ||
            cout !== 1'b0 || err !== 1'b0 || dig_a !== 4'd0 || dig_b !== 4'd0 || dig_cin !== 1'b0) begin
            errors++;
            $display("FAIL midreset async: ov %b ir %b busy %b res %h cout %b err %b dig %h %h %b",
                     out_valid, in_ready, busy, result, cout, err, dig_a, dig_b, dig_cin);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 5, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_ripple();
        test_bad_digit();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
